ras_ctrl: RTL and testbench
===========================

# ras_ctrl

Return-address stack controller for the MUSA core. It sequences a single-port, synchronous-read stack RAM of PC-width words and shares it between two requesters: the core control unit (CALL/RET) and the interrupt controller (interrupt entry/RETI). It owns the stack pointer and the full/empty state, and reports overflow and underflow. It replaces the unclocked push/pop stack with a clocked, handshaked sequencer in front of a plain memory.

## Interface
- WIDTH, 18, PC/return-address width.
- AW, 4, stack RAM address width; depth is 2**AW entries.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- call_req  in  1  core push request, level, held until core_ack.
- ret_req  in  1  core pop request, level, held until core_ack.
- call_pc  in  WIDTH  return address to push for CALL.
- core_ack  out  1  one-cycle grant-complete pulse to the core.
- int_req  in  1  interrupt-entry push request, held until int_ack.
- iret_req  in  1  RETI pop request, held until int_ack.
- int_pc  in  WIDTH  interrupted PC to push.
- int_ack  out  1  one-cycle grant-complete pulse to the interrupt controller.
- ret_addr  out  WIDTH  last popped address, registered, held.
- ret_valid  out  1  one-cycle pulse; ret_addr is new this cycle.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  WIDTH  RAM write data.
- mem_rdata  in  WIDTH  RAM read data, valid the cycle after the address is presented.
- sp  out  AW+1  occupancy, 0..2**AW.
- full  out  1  sp == 2**AW.
- empty  out  1  sp == 0.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.
- err_clr  in  1  synchronous clear of overflow/underflow.

## Operation
- States: IDLE, PUSH, POP_RD, POP_WB.
- IDLE: sample requests each cycle. Fixed priority: int_req > iret_req > call_req > ret_req. Latch the winner, its owner and its push data (int_pc/call_pc). Go to PUSH or POP_RD. No request: stay.
- PUSH, one cycle:
  - Not full: mem_we=1, mem_addr=sp[AW-1:0], mem_wdata=latched data; sp<=sp+1.
  - Full: mem_we=0, sp unchanged, overflow<=1.
  - Owner's ack=1 either way. Next state IDLE.
- POP_RD, one cycle:
  - Not empty: mem_addr=sp-1, mem_we=0; sp<=sp-1.
  - Empty: sp unchanged, underflow<=1, mark result invalid.
  - Next state POP_WB.
- POP_WB, one cycle: owner's ack=1. At the clock edge, ret_addr<=mem_rdata, or all-zeros if the pop underflowed. Next state IDLE.
- ret_valid=1 in the cycle after POP_WB.
- mem_we=0 and mem_addr=0 in all states other than PUSH/POP_RD.
- mem_wdata always drives the latched data.
- err_clr clears both sticky flags. A new error in the same cycle wins (flag stays 1).
- sp arithmetic is AW+1 bits and never wraps: pushes saturate at 2**AW (overflow), pops saturate at 0 (underflow).
- Reset (async, any state): state=IDLE, sp=0, ret_addr=0, all acks/ret_valid/mem_we/overflow/underflow=0, latched data=0. An in-flight op is abandoned with no ack. RAM contents are not cleared.

## Timing
- Request sampled at edge E0 (IDLE).
- Push: write and ack in cycle E0+1; sp updates at edge E0+2.
- Pop: address in cycle E0+1; ack in cycle E0+2; ret_addr/ret_valid in cycle E0+3.
- Requesters deassert req at the edge after seeing ack. The controller is back in IDLE in the cycle after ack, so a still-high req is taken as a new request.
- Back-to-back throughput: push every 2 cycles, pop every 3.
- Only one operation is in flight. Requests arriving while not in IDLE wait; no queueing beyond the held level.
- full/empty/sp are combinational from the sp register.

## Test plan
- Reset, then call_req with call_pc=0x0ABCD: core_ack at E0+1; RAM[0]=0x0ABCD; sp=1. Then ret_req: ret_addr=0x0ABCD with ret_valid at E0+3; sp=0; empty=1.
- Push 16 distinct values (AW=4), then a 17th: full=1, overflow=1, sp=16, no RAM write, core_ack still pulses. Pop 16: values return in LIFO order.
- ret_req on empty: underflow=1, ret_addr=0, ret_valid pulses, sp stays 0. Then err_clr=1: underflow=0. err_clr coincident with a new underflow: flag stays 1.
- call_req and int_req raised together with int_pc=0x00100 and call_pc=0x00200: int_ack first, RAM[0]=0x00100. Core is served next, RAM[1]=0x00200. iret_req then pops 0x00200 (LIFO, shared stack).
- Assert rst_n=0 during POP_WB: no ack, sp=0, ret_addr=0, state IDLE. The next push writes RAM[0].
- All four requests high together: service order is int, iret, call, ret across four handshakes, each ack going to the correct owner.

Source files
------------

// File: rtl/ras_ctrl.sv
// Return-address stack sequencer shared by the core (CALL/RET) and the interrupt controller (entry/RETI).
// Fronts a single-port, synchronous-read RAM and owns the stack pointer and sticky error flags.
module ras_ctrl #(
  parameter int WIDTH = 18,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             call_req,
  input  logic             ret_req,
  input  logic [WIDTH-1:0] call_pc,
  output logic             core_ack,
  input  logic             int_req,
  input  logic             iret_req,
  input  logic [WIDTH-1:0] int_pc,
  output logic             int_ack,
  output logic [WIDTH-1:0] ret_addr,
  output logic             ret_valid,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [AW:0]      sp,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PUSH, POP_RD, POP_WB} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [AW:0]      r_sp;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_retAddr;
  logic             r_ownerInt;
  logic             r_popEmpty;
  logic             r_retValid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic [AW-1:0]    w_topAddr;
  logic             w_reqValid;
  logic             w_reqPush;
  logic             w_reqInt;
  logic [WIDTH-1:0] w_reqData;
  logic             w_doPush;
  logic             w_doPop;
  logic             w_pushErr;
  logic             w_popErr;
  logic             w_coreAck;
  logic             w_intAck;
  logic             w_memWe;
  logic [AW-1:0]    w_memAddr;

  assign w_full    = (r_sp == DEPTH);
  assign w_empty   = (r_sp == '0);
  // Low bits of sp-1; only used when the stack is non-empty.
  assign w_topAddr = r_sp[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

  assign w_doPush  = (r_state == PUSH)   && !w_full;
  assign w_pushErr = (r_state == PUSH)   &&  w_full;
  assign w_doPop   = (r_state == POP_RD) && !w_empty;
  assign w_popErr  = (r_state == POP_RD) &&  w_empty;

  // Fixed-priority arbitration: int_req > iret_req > call_req > ret_req.
  always_comb begin
    w_reqValid = 1'b1;
    w_reqPush  = 1'b0;
    w_reqInt   = 1'b0;
    w_reqData  = r_data;
    if (int_req) begin
      w_reqPush = 1'b1;
      w_reqInt  = 1'b1;
      w_reqData = int_pc;
    end else if (iret_req) begin
      w_reqInt  = 1'b1;
    end else if (call_req) begin
      w_reqPush = 1'b1;
      w_reqData = call_pc;
    end else if (!ret_req) begin
      w_reqValid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_memWe     = 1'b0;
    w_memAddr   = '0;
    w_coreAck   = 1'b0;
    w_intAck    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_reqValid) begin
          w_nextState = w_reqPush ? PUSH : POP_RD;
        end
      end
      PUSH: begin
        if (!w_full) begin
          w_memWe   = 1'b1;
          w_memAddr = r_sp[AW-1:0];
        end
        w_coreAck   = !r_ownerInt;
        w_intAck    =  r_ownerInt;
        w_nextState = IDLE;
      end
      POP_RD: begin
        if (!w_empty) begin
          w_memAddr = w_topAddr;
        end
        w_nextState = POP_WB;
      end
      POP_WB: begin
        w_coreAck   = !r_ownerInt;
        w_intAck    =  r_ownerInt;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // The winner's owner and push data are captured only when a new operation starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ownerInt <= 1'b0;
      r_data     <= '0;
    end else if (r_state == IDLE && w_reqValid) begin
      r_ownerInt <= w_reqInt;
      r_data     <= w_reqData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (w_doPush) begin
      r_sp <= r_sp + ONE;
    end else if (w_doPop) begin
      r_sp <= r_sp - ONE;
    end
  end

  // An underflowing pop still completes, but returns zero instead of stale RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_popEmpty <= 1'b0;
      r_retAddr  <= '0;
      r_retValid <= 1'b0;
    end else begin
      if (r_state == POP_RD) begin
        r_popEmpty <= w_empty;
      end
      if (r_state == POP_WB) begin
        r_retAddr <= r_popEmpty ? '0 : mem_rdata;
      end
      r_retValid <= (r_state == POP_WB);
    end
  end

  // A fresh error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_pushErr) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_popErr) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign core_ack  = w_coreAck;
  assign int_ack   = w_intAck;
  assign mem_we    = w_memWe;
  assign mem_addr  = w_memAddr;
  assign mem_wdata = r_data;
  assign ret_addr  = r_retAddr;
  assign ret_valid = r_retValid;
  assign sp        = r_sp;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: directed scenarios plus random CALL/RET/INT/RETI traffic
// compared against a queue-based LIFO model.
module tb_ras_ctrl;

  localparam int WIDTH = 18;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             call_req = 1'b0;
  logic             ret_req = 1'b0;
  logic [WIDTH-1:0] call_pc = '0;
  logic             core_ack;
  logic             int_req = 1'b0;
  logic             iret_req = 1'b0;
  logic [WIDTH-1:0] int_pc = '0;
  logic             int_ack;
  logic [WIDTH-1:0] ret_addr;
  logic             ret_valid;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic [AW:0]      sp;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
  logic             err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Behavioural model: stack contents and sticky flags
  logic [WIDTH-1:0] model[$];
  bit               mOver;
  bit               mUnder;

  // Single-port synchronous-read RAM
  logic [WIDTH-1:0] ram [0:DEPTH-1];
  int               ramWrites = 0;

  ras_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .call_req(call_req), .ret_req(ret_req), .call_pc(call_pc), .core_ack(core_ack),
    .int_req(int_req), .iret_req(iret_req), .int_pc(int_pc), .int_ack(int_ack),
    .ret_addr(ret_addr), .ret_valid(ret_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sp(sp), .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      ramWrites     <= ramWrites + 1;
    end
    mem_rdata <= ram[mem_addr];
  end

  // kind: 0=int entry, 1=RETI, 2=CALL, 3=RET
  task automatic setReq(input int kind, input logic val);
    case (kind)
      0: int_req  = val;
      1: iret_req = val;
      2: call_req = val;
      default: ret_req = val;
    endcase
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    int_req = 0; iret_req = 0; call_req = 0; ret_req = 0; err_clr = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model.delete();
    mOver  = 0;
    mUnder = 0;
  endtask

  task automatic modelOp(input int kind, input logic [WIDTH-1:0] data, output logic [WIDTH-1:0] expRet);
    expRet = '0;
    if (kind == 0 || kind == 2) begin
      if (model.size() < DEPTH) model.push_back(data);
      else mOver = 1;
    end else begin
      if (model.size() > 0) expRet = model.pop_back();
      else mUnder = 1;
    end
  endtask

  task automatic waitAck(output int lat, output logic gotCore, output logic gotInt);
    lat = 0; gotCore = 0; gotInt = 0;
    while (lat < 20 && !gotCore && !gotInt) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      gotCore = core_ack;
      gotInt  = int_ack;
    end
    if (!gotCore && !gotInt) lat = -1;
  endtask

  task automatic finishOp(input int kind, output logic rv, output logic [WIDTH-1:0] ra);
    @(posedge clk); #1;
    setReq(kind, 1'b0);
    @(negedge clk);
    rv = ret_valid;
    ra = ret_addr;
  endtask

  task automatic runOp(input int kind, input logic [WIDTH-1:0] data, output int lat,
                       output logic gotCore, output logic gotInt, output logic rv,
                       output logic [WIDTH-1:0] ra);
    int_pc  = (kind == 0) ? data : ~data;
    call_pc = (kind == 2) ? data : ~data;
    setReq(kind, 1'b1);
    waitAck(lat, gotCore, gotInt);
    finishOp(kind, rv, ra);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (sp !== 5'd0) begin errors++; $display("[TB] FAIL reset_sp got %0d exp 0", sp); end
    checks++; if ({full, empty} !== 2'b01) begin errors++; $display("[TB] FAIL reset_full_empty got %b exp 01", {full, empty}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b exp 00", {overflow, underflow}); end
    checks++; if ({core_ack, int_ack, ret_valid, mem_we} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pulses got %b exp 0000", {core_ack, int_ack, ret_valid, mem_we}); end
    checks++; if (ret_addr !== 18'h0) begin errors++; $display("[TB] FAIL reset_ret_addr got %h exp 0", ret_addr); end
    checks++; if ({mem_addr, mem_wdata} !== '0) begin errors++; $display("[TB] FAIL reset_mem_bus got %h/%h exp 0/0", mem_addr, mem_wdata); end
    doReset();
  endtask

  task automatic test_call_ret();
    int lat; logic c, i, rv; logic [WIDTH-1:0] ra;
    doReset();
    runOp(2, 18'h0ABCD, lat, c, i, rv, ra);
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL call_latency got %0d exp 1", lat); end
    checks++; if ({i, c} !== 2'b01) begin errors++; $display("[TB] FAIL call_owner got %b exp 01", {i, c}); end
    checks++; if (ram[0] !== 18'h0ABCD) begin errors++; $display("[TB] FAIL call_ram0 got %h exp 0abcd", ram[0]); end
    checks++; if (sp !== 5'd1) begin errors++; $display("[TB] FAIL call_sp got %0d exp 1", sp); end
    runOp(3, 18'h0, lat, c, i, rv, ra);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL ret_latency got %0d exp 2", lat); end
    checks++; if ({i, c} !== 2'b01) begin errors++; $display("[TB] FAIL ret_owner got %b exp 01", {i, c}); end
    checks++; if ({rv, ra} !== {1'b1, 18'h0ABCD}) begin errors++; $display("[TB] FAIL ret_value got %b/%h exp 1/0abcd", rv, ra); end
    checks++; if ({sp, empty} !== {5'd0, 1'b1}) begin errors++; $display("[TB] FAIL ret_sp_empty got %0d/%b exp 0/1", sp, empty); end
    @(negedge clk);
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("[TB] FAIL ret_valid_pulse got %b exp 0", ret_valid); end
  endtask

  task automatic test_overflow();
    int lat, w0; logic c, i, rv; logic [WIDTH-1:0] ra, d;
    doReset();
    for (int k = 0; k < DEPTH; k++) begin
      d = 18'h01000 + 18'(k * 'h111);
      runOp(2, d, lat, c, i, rv, ra);
      checks++; if (ram[k] !== d) begin errors++; $display("[TB] FAIL fill_ram%0d got %h exp %h", k, ram[k], d); end
    end
    checks++; if ({sp, full, overflow} !== {5'd16, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL fill_state got %0d/%b/%b exp 16/1/0", sp, full, overflow); end
    w0 = ramWrites;
    runOp(2, 18'h3FFFF, lat, c, i, rv, ra);
    checks++; if (lat !== 1 || {i, c} !== 2'b01) begin errors++; $display("[TB] FAIL ovf_ack got lat %0d owner %b exp 1/01", lat, {i, c}); end
    checks++; if ({sp, full, overflow} !== {5'd16, 1'b1, 1'b1}) begin errors++; $display("[TB] FAIL ovf_state got %0d/%b/%b exp 16/1/1", sp, full, overflow); end
    checks++; if (ramWrites !== w0) begin errors++; $display("[TB] FAIL ovf_no_write got %0d writes exp %0d", ramWrites, w0); end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      d = 18'h01000 + 18'(k * 'h111);
      runOp(3, 18'h0, lat, c, i, rv, ra);
      checks++; if ({rv, ra} !== {1'b1, d}) begin errors++; $display("[TB] FAIL lifo_pop%0d got %b/%h exp 1/%h", k, rv, ra, d); end
    end
    checks++; if ({sp, empty, overflow, underflow} !== {5'd0, 1'b1, 1'b1, 1'b0}) begin errors++; $display("[TB] FAIL drain_state got %0d/%b/%b/%b exp 0/1/1/0", sp, empty, overflow, underflow); end
  endtask

  task automatic test_underflow();
    int lat; logic c, i, rv; logic [WIDTH-1:0] ra;
    doReset();
    runOp(3, 18'h0, lat, c, i, rv, ra);
    checks++; if (lat !== 2 || {i, c} !== 2'b01) begin errors++; $display("[TB] FAIL unf_ack got lat %0d owner %b exp 2/01", lat, {i, c}); end
    checks++; if ({rv, ra} !== {1'b1, 18'h0}) begin errors++; $display("[TB] FAIL unf_ret got %b/%h exp 1/0", rv, ra); end
    checks++; if ({sp, underflow} !== {5'd0, 1'b1}) begin errors++; $display("[TB] FAIL unf_state got %0d/%b exp 0/1", sp, underflow); end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL err_clr got %b exp 0", underflow); end
    // err_clr held exactly during the POP_RD cycle of a second empty pop
    ret_req = 1'b1;
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    checks++; if (core_ack !== 1'b1) begin errors++; $display("[TB] FAIL unf2_ack got %b exp 1", core_ack); end
    @(posedge clk); #1 ret_req = 1'b0;
    @(negedge clk);
    checks++; if ({underflow, overflow} !== 2'b10) begin errors++; $display("[TB] FAIL clr_vs_set got %b exp 10", {underflow, overflow}); end
  endtask

  task automatic test_priority();
    int lat; logic c, i, rv; logic [WIDTH-1:0] ra;
    doReset();
    int_pc = 18'h00100; call_pc = 18'h00200;
    int_req = 1'b1; call_req = 1'b1;
    waitAck(lat, c, i);
    checks++; if (lat !== 1 || {i, c} !== 2'b10) begin errors++; $display("[TB] FAIL prio_first got lat %0d owner %b exp 1/10", lat, {i, c}); end
    @(posedge clk); #1 int_req = 1'b0;
    waitAck(lat, c, i);
    checks++; if (lat !== 1 || {i, c} !== 2'b01) begin errors++; $display("[TB] FAIL prio_second got lat %0d owner %b exp 1/01", lat, {i, c}); end
    finishOp(2, rv, ra);
    checks++; if ({ram[0], ram[1]} !== {18'h00100, 18'h00200}) begin errors++; $display("[TB] FAIL prio_ram got %h/%h exp 00100/00200", ram[0], ram[1]); end
    runOp(1, 18'h0, lat, c, i, rv, ra);
    checks++; if ({i, c} !== 2'b10) begin errors++; $display("[TB] FAIL iret_owner got %b exp 10", {i, c}); end
    checks++; if ({rv, ra} !== {1'b1, 18'h00200}) begin errors++; $display("[TB] FAIL iret_value got %b/%h exp 1/00200", rv, ra); end
  endtask

  task automatic test_reset_midpop();
    int lat; logic c, i, rv; logic [WIDTH-1:0] ra;
    doReset();
    runOp(2, 18'h15555, lat, c, i, rv, ra);
    runOp(2, 18'h0AAAA, lat, c, i, rv, ra);
    runOp(3, 18'h0, lat, c, i, rv, ra);
    runOp(2, 18'h12345, lat, c, i, rv, ra);
    ret_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({core_ack, int_ack} !== 2'b00) begin errors++; $display("[TB] FAIL midpop_ack got %b exp 00", {core_ack, int_ack}); end
    checks++; if (sp !== 5'd0) begin errors++; $display("[TB] FAIL midpop_sp got %0d exp 0", sp); end
    checks++; if (ret_addr !== 18'h0) begin errors++; $display("[TB] FAIL midpop_ret_addr got %h exp 0", ret_addr); end
    ret_req = 1'b0;
    @(negedge clk);
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("[TB] FAIL midpop_ret_valid got %b exp 0", ret_valid); end
    @(posedge clk); #1 rst_n = 1'b1;
    model.delete(); mOver = 0; mUnder = 0;
    runOp(2, 18'h2BEEF, lat, c, i, rv, ra);
    checks++; if (lat !== 1 || ram[0] !== 18'h2BEEF || sp !== 5'd1) begin errors++; $display("[TB] FAIL postreset_push got lat %0d ram0 %h sp %0d exp 1/2beef/1", lat, ram[0], sp); end
  endtask

  task automatic test_all_four();
    int lat; logic c, i, rv; logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] expRet [4];
    expRet[0] = 18'h0; expRet[1] = 18'h00111; expRet[2] = 18'h0; expRet[3] = 18'h00222;
    doReset();
    int_pc = 18'h00111; call_pc = 18'h00222;
    int_req = 1; iret_req = 1; call_req = 1; ret_req = 1;
    for (int k = 0; k < 4; k++) begin
      waitAck(lat, c, i);
      checks++; if (lat !== ((k % 2 == 0) ? 1 : 2) || {i, c} !== ((k < 2) ? 2'b10 : 2'b01)) begin
        errors++; $display("[TB] FAIL all4_step%0d got lat %0d owner %b", k, lat, {i, c});
      end
      finishOp(k, rv, ra);
      if (k % 2 == 1) begin
        checks++; if ({rv, ra} !== {1'b1, expRet[k]}) begin errors++; $display("[TB] FAIL all4_pop%0d got %b/%h exp 1/%h", k, rv, ra, expRet[k]); end
      end
    end
    checks++; if (sp !== 5'd0) begin errors++; $display("[TB] FAIL all4_sp got %0d exp 0", sp); end
  endtask

  task automatic test_random();
    int lat, kind; logic c, i, rv; logic [WIDTH-1:0] ra, d, er;
    doReset();
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      d    = WIDTH'($urandom);
      modelOp(kind, d, er);
      runOp(kind, d, lat, c, i, rv, ra);
      checks++; if (lat !== ((kind % 2 == 0) ? 1 : 2) || {i, c} !== ((kind < 2) ? 2'b10 : 2'b01)) begin
        errors++; $display("[TB] FAIL rnd%0d_ack kind %0d got lat %0d owner %b", n, kind, lat, {i, c});
      end
      checks++; if (rv !== (kind % 2 == 1) || (rv && ra !== er)) begin
        errors++; $display("[TB] FAIL rnd%0d_ret kind %0d got %b/%h exp %b/%h", n, kind, rv, ra, kind % 2 == 1, er);
      end
      checks++; if (sp !== 5'(model.size()) || full !== (model.size() == DEPTH) || empty !== (model.size() == 0)) begin
        errors++; $display("[TB] FAIL rnd%0d_sp got %0d/%b/%b exp %0d", n, sp, full, empty, model.size());
      end
      checks++; if ({overflow, underflow} !== {mOver, mUnder}) begin
        errors++; $display("[TB] FAIL rnd%0d_flags got %b exp %b", n, {overflow, underflow}, {mOver, mUnder});
      end
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        mOver = 0; mUnder = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_priority();
    test_reset_midpop();
    test_all_four();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
